// File: rtl/reset_request_pkg.sv
// reset_request_pkg: FSM states and cause bit positions shared by the reset request block
package reset_request_pkg;
  typedef enum logic [1:0] {IDLE, TRIGGER, WAIT_ASSERT, WAIT_RELEASE} state_t;
  localparam int CAUSE_BTN = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_SW  = 2;
  localparam int CAUSE_W   = 3;
endpackage

// File: rtl/reset_debounce.sv
// reset_debounce: synchronises the active-low pushbutton and debounces it, flagging each debounced press
module reset_debounce #(
  parameter int WIDTH = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button_n,
  output logic o_level,
  output logic o_fall
);
  logic [1:0]       r_sync;
  logic             r_level;
  logic [WIDTH-1:0] r_cnt;
  logic             w_diff;
  logic             w_full;
  assign w_diff  = r_sync[1] ^ r_level;
  assign w_full  = &r_cnt;
  assign o_level = r_level;
  // The press is flagged on the cycle the level is about to flip from 1 to 0.
  assign o_fall  = w_diff & w_full & r_level;
  // Two-stage synchroniser, then count how long the synced input has disagreed with the debounced level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_button_n};
      if (!w_diff) r_cnt <= '0;
      else if (w_full) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/reset_request.sv
// reset_request: issues one trigger pulse per reset cycle from button/watchdog/software causes; watchdog built only with RESET_REQUEST_WDT_EN
module reset_request
  import reset_request_pkg::*;
#(
  parameter int DB_WIDTH  = 16,
  parameter int WDT_WIDTH = 24
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               button_ni,
  input  logic               wdt_en_i,
  input  logic               wdt_kick_i,
  input  logic               sw_req_i,
  input  logic               reset_i,
  output logic               trigger_o,
  output logic [CAUSE_W-1:0] cause_o
);
  state_t             r_state;
  logic               r_trigger;
  logic [CAUSE_W-1:0] r_cause;
  logic [CAUSE_W-1:0] w_event;
  logic               w_btn_level;
  logic               w_press;
  logic               w_timeout;
  reset_debounce #(.WIDTH(DB_WIDTH)) u_debounce (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_button_n (button_ni),
    .o_level    (w_btn_level),
    .o_fall     (w_press)
  );
`ifdef RESET_REQUEST_WDT_EN
  logic [WDT_WIDTH-1:0] r_wdt_cnt;
  logic                 w_wdt_clr;
  logic                 w_unused;
  assign w_unused  = w_btn_level;
  // Counting only makes sense while idle and out of reset with the dog enabled and unkicked.
  assign w_wdt_clr = wdt_kick_i | ~wdt_en_i | reset_i | (r_state != IDLE);
  assign w_timeout = ~w_wdt_clr & (&r_wdt_cnt);
  // Watchdog counter wraps to zero after signalling a timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_wdt_cnt <= '0;
    else r_wdt_cnt <= (w_wdt_clr | w_timeout) ? '0 : r_wdt_cnt + 1'b1;
  end
`else
  logic w_unused;
  assign w_unused  = &{1'b0, wdt_en_i, wdt_kick_i, w_btn_level, WDT_WIDTH[0]};
  assign w_timeout = 1'b0;
`endif
  assign w_event[CAUSE_BTN] = w_press;
  assign w_event[CAUSE_WDT] = w_timeout;
  assign w_event[CAUSE_SW]  = sw_req_i;
  assign trigger_o = r_trigger;
  assign cause_o   = r_cause;
  // Request FSM: accept events only in IDLE outside reset, then follow the generator through one reset cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_trigger <= 1'b0;
      r_cause   <= '0;
    end else begin
      r_trigger <= 1'b0;
      case (r_state)
        IDLE: if ((|w_event) && !reset_i) begin
          r_state   <= TRIGGER;
          r_trigger <= 1'b1;
          r_cause   <= w_event;
        end
        TRIGGER:      r_state <= WAIT_ASSERT;
        WAIT_ASSERT:  if (reset_i) r_state <= WAIT_RELEASE;
        WAIT_RELEASE: if (!reset_i) r_state <= IDLE;
        default:      r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reset_request.sv
// tb_reset_request: scoreboard bench for reset_request with a small CPU reset generator model; honours RESET_REQUEST_WDT_EN
module tb_reset_request;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       button_ni = 1'b1;
  logic       wdt_en_i = 1'b0;
  logic       wdt_kick_i = 1'b0;
  logic       sw_req_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       por = 1'b0;
  logic       trigger_o;
  logic [2:0] cause_o;
  logic [2:0] sb[$];
  logic [2:0] last_exp = 3'b000;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int last_pulse = 0;
  int cyc = 0;
  int gen_cnt = 0;
  int rst_len = 7;

  reset_request #(.DB_WIDTH(4), .WDT_WIDTH(6)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .button_ni  (button_ni),
    .wdt_en_i   (wdt_en_i),
    .wdt_kick_i (wdt_kick_i),
    .sw_req_i   (sw_req_i),
    .reset_i    (reset_i),
    .trigger_o  (trigger_o),
    .cause_o    (cause_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  // CPU reset generator model: reset_i rises 3 cycles after a trigger and holds for rst_len cycles
  always @(negedge clk_i) begin
    if (trigger_o) gen_cnt = rst_len + 3;
    else if (gen_cnt > 0) gen_cnt--;
    reset_i = por | (gen_cnt > 0 && gen_cnt <= rst_len);
  end

  // scoreboard consumer: every trigger pulse must match the oldest expected cause
  always @(negedge clk_i) begin
    if (trigger_o) begin
      logic [2:0] exp;
      pulses++;
      last_pulse = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cause_o=%b expected no pulse", cause_o);
      end else begin
        exp = sb.pop_front();
        if (cause_o !== exp) begin
          errors++;
          $display("FAIL pulse_cause got=%b exp=%b", cause_o, exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic sw_pulse();
    sw_req_i = 1'b1;
    tick(1);
    sw_req_i = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || gen_cnt != 0 || reset_i) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d expected 0 within %0d cycles", name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if (trigger_o !== 1'b0) begin errors++; $display("FAIL reset_trigger got=%b exp=0", trigger_o); end
    checks++;
    if (cause_o !== 3'b000) begin errors++; $display("FAIL reset_cause got=%b exp=000", cause_o); end
    rst_i = 1'b0;
    tick(20);
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_idle_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_button();
    int p0 = pulses;
    int t0;
    sb.push_back(3'b001);
    last_exp = 3'b001;
    button_ni = 1'b0;
    t0 = cyc;
    tick(30);
    button_ni = 1'b1;
    wait_quiet("button", 100);
    tick(25);
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL button_count got=%0d exp=1", pulses - p0); end
    checks++;
    if (last_pulse - t0 < 15 || last_pulse - t0 > 20) begin
      errors++;
      $display("FAIL button_latency got=%0d exp=15..20", last_pulse - t0);
    end
    checks++;
    if (cause_o !== 3'b001) begin errors++; $display("FAIL button_cause got=%b exp=001", cause_o); end
    p0 = pulses;
    button_ni = 1'b0;
    tick(8);
    button_ni = 1'b1;
    tick(40);
    checks++;
    if (pulses !== p0) begin errors++; $display("FAIL glitch_pulses got=%0d exp=0", pulses - p0); end
  endtask

  task automatic test_sw();
    int p0 = pulses;
    sb.push_back(3'b100);
    last_exp = 3'b100;
    sw_pulse();
    checks++;
    if (trigger_o !== 1'b1) begin errors++; $display("FAIL sw_trigger_k got=%b exp=1", trigger_o); end
    tick(1);
    checks++;
    if (trigger_o !== 1'b0) begin errors++; $display("FAIL sw_trigger_k1 got=%b exp=0", trigger_o); end
    wait_quiet("sw", 60);
    checks++;
    if (cause_o !== 3'b100) begin errors++; $display("FAIL sw_cause got=%b exp=100", cause_o); end
    sb.push_back(3'b100);
    sw_pulse();
    wait_quiet("sw_again", 60);
    checks++;
    if (pulses - p0 !== 2) begin errors++; $display("FAIL sw_return_idle got=%0d exp=2", pulses - p0); end
  endtask

  task automatic test_wdt();
    int p0 = pulses;
    int t0;
    int n = 0;
`ifdef RESET_REQUEST_WDT_EN
    sb.push_back(3'b010);
    last_exp = 3'b010;
    wdt_en_i = 1'b1;
    t0 = cyc;
    while (pulses == p0 && n < 100) begin tick(1); n++; end
    wdt_en_i = 1'b0;
    wait_quiet("wdt", 60);
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL wdt_count got=%0d exp=1", pulses - p0); end
    checks++;
    if (last_pulse - t0 < 62 || last_pulse - t0 > 66) begin
      errors++;
      $display("FAIL wdt_latency got=%0d exp=62..66", last_pulse - t0);
    end
    checks++;
    if (cause_o !== 3'b010) begin errors++; $display("FAIL wdt_cause got=%b exp=010", cause_o); end
`else
    t0 = cyc;
    wdt_en_i = 1'b1;
    while (n < 200) begin tick(1); n++; end
    wdt_en_i = 1'b0;
    checks++;
    if (pulses !== p0) begin errors++; $display("FAIL wdt_off_pulses got=%0d exp=0 after %0d", pulses - p0, cyc - t0); end
    checks++;
    if (cause_o[1] !== 1'b0) begin errors++; $display("FAIL wdt_off_cause1 got=%b exp=0", cause_o[1]); end
`endif
    p0 = pulses;
    wdt_en_i = 1'b1;
    for (int i = 0; i < 500; i++) begin
      wdt_kick_i = (i % 40 == 39);
      tick(1);
    end
    wdt_kick_i = 1'b0;
    wdt_en_i = 1'b0;
    checks++;
    if (pulses !== p0) begin errors++; $display("FAIL wdt_kicked_pulses got=%0d exp=0", pulses - p0); end
  endtask

  task automatic test_back_to_back();
    int p0 = pulses;
`ifdef RESET_REQUEST_WDT_EN
    logic [2:0] exp = 3'b110;
`else
    logic [2:0] exp = 3'b100;
`endif
    sb.push_back(exp);
    last_exp = exp;
    wdt_en_i = 1'b1;
    tick(63);
    sw_pulse();
    wdt_en_i = 1'b0;
    wait_quiet("simul", 60);
    tick(10);
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL simul_count got=%0d exp=1", pulses - p0); end
    checks++;
    if (cause_o !== exp) begin errors++; $display("FAIL simul_cause got=%b exp=%b", cause_o, exp); end
  endtask

  task automatic test_dropped();
    int p0 = pulses;
    int n = 0;
    por = 1'b1;
    tick(1);
    sw_pulse();
    button_ni = 1'b0;
    tick(30);
    button_ni = 1'b1;
    tick(30);
    por = 1'b0;
    tick(20);
    checks++;
    if (pulses !== p0) begin errors++; $display("FAIL por_pulses got=%0d exp=0", pulses - p0); end
    checks++;
    if (cause_o !== last_exp) begin errors++; $display("FAIL por_cause got=%b exp=%b", cause_o, last_exp); end
    rst_len = 40;
    sb.push_back(3'b100);
    last_exp = 3'b100;
    sw_pulse();
    while (!reset_i && n < 20) begin tick(1); n++; end
    tick(1);
    sw_pulse();
    button_ni = 1'b0;
    tick(25);
    button_ni = 1'b1;
    wait_quiet("wait_release", 150);
    tick(25);
    rst_len = 7;
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL wait_release_pulses got=%0d exp=1", pulses - p0); end
    checks++;
    if (cause_o !== 3'b100) begin errors++; $display("FAIL wait_release_cause got=%b exp=100", cause_o); end
  endtask

  task automatic test_rst_mid();
    int p0;
    sw_pulse();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (trigger_o !== 1'b0) begin errors++; $display("FAIL rst_in_trigger got=%b exp=0", trigger_o); end
    tick(2);
    rst_i = 1'b0;
    tick(5);
    sb.push_back(3'b100);
    sw_pulse();
    tick(1);
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (trigger_o !== 1'b0) begin errors++; $display("FAIL rst_wait_trigger got=%b exp=0", trigger_o); end
    checks++;
    if (cause_o !== 3'b000) begin errors++; $display("FAIL rst_wait_cause got=%b exp=000", cause_o); end
    tick(2);
    rst_i = 1'b0;
    wait_quiet("rst_mid", 60);
    tick(5);
    p0 = pulses;
    sb.push_back(3'b100);
    sw_pulse();
    wait_quiet("after_rst", 60);
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL after_rst_pulses got=%0d exp=1", pulses - p0); end
    checks++;
    if (cause_o !== 3'b100) begin errors++; $display("FAIL after_rst_cause got=%b exp=100", cause_o); end
  endtask

  initial begin
    test_reset();
    test_button();
    test_sw();
    test_wdt();
    test_back_to_back();
    test_dropped();
    test_rst_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
